// File: rtl/z80_cmd_mailbox.sv
// z80_cmd_mailbox: queues Z80 OUT writes to CMD_PORT as {addr,data} and hands them to NIOS over a 4-phase handshake
// Ports: clk/reset (async, active-high); z80_iorq_n/z80_rd_n/z80_wr_n/z80_m1_n/z80_addr/z80_data_in from the Z80 bus;
//   z80_data_out/z80_data_oe return the status byte {4'b0, timeout_err, overflow, fifo_full, busy};
//   cpu_cmd/cpu_address/cpu_cmd_en/cpu_cmd_ack form the NIOS PIO handshake; busy = FIFO non-empty or handshake active.
// Optional: define CMD_TIMEOUT_EN to abandon a handshake after TIMEOUT_CYCLES and flag timeout_err.
module z80_cmd_mailbox #(
  parameter logic [7:0] CMD_PORT       = 8'h3F,
  parameter int         FIFO_AW        = 2,
  parameter int         TIMEOUT_CYCLES = 50000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        z80_iorq_n,
  input  logic        z80_rd_n,
  input  logic        z80_wr_n,
  input  logic        z80_m1_n,
  input  logic [15:0] z80_addr,
  input  logic [7:0]  z80_data_in,
  output logic [7:0]  z80_data_out,
  output logic        z80_data_oe,
  output logic [7:0]  cpu_cmd,
  output logic [15:0] cpu_address,
  output logic        cpu_cmd_en,
  input  logic        cpu_cmd_ack,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, REQ, REL} state_t;
  localparam int DEPTH = 2 ** FIFO_AW;
  logic [1:0] iorq_q, rd_q, wr_q, m1_q, ack_q;
  logic port_hit, wr_hit, rd_hit, wr_hit_q, rd_hit_q, push, rd_rise;
  logic full, pop, push_ok, timeout, tmo_err, ovf_q, ovf_d;
  logic [23:0] mem_q [DEPTH];
  logic [FIFO_AW-1:0] wp_q, rp_q;
  logic [FIFO_AW:0] cnt_q;
  state_t state_q, state_d;
  logic [7:0] cmd_q, status_q;
  logic [15:0] addr_q;
  assign port_hit = z80_addr[7:0] == CMD_PORT;
  assign wr_hit = ~iorq_q[1] & ~wr_q[1] & m1_q[1] & port_hit;
  assign rd_hit = ~iorq_q[1] & ~rd_q[1] & m1_q[1] & port_hit;
  assign push = wr_hit & ~wr_hit_q;
  assign rd_rise = rd_hit & ~rd_hit_q;
  assign full = cnt_q == (FIFO_AW+1)'(DEPTH);
  assign pop = (state_q == IDLE) & (cnt_q != '0);
  // a pop in the same cycle frees the slot, so a push into a full FIFO still lands
  assign push_ok = push & (~full | pop);
  assign ovf_d = (push & ~push_ok) | (ovf_q & ~rd_rise);
  assign busy = (cnt_q != '0) | (state_q != IDLE);
  assign cpu_cmd_en = state_q == REQ;
  assign cpu_cmd = cmd_q;
  assign cpu_address = addr_q;
  assign z80_data_out = status_q;
  // the Z80 samples the bus within its own read cycle, so the enable bypasses the synchronisers
  assign z80_data_oe = ~reset & ~z80_iorq_n & ~z80_rd_n & z80_m1_n & port_hit;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = (cnt_q != '0) ? REQ : IDLE;
      REQ:     state_d = ack_q[1] ? REL : REQ;
      REL:     state_d = ack_q[1] ? REL : IDLE;
      default: state_d = IDLE;
    endcase
    if (timeout) state_d = IDLE;
  end
`ifdef CMD_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tcnt_q;
  logic err_q;
  assign timeout = (state_q != IDLE) & (tcnt_q == TW'(TIMEOUT_CYCLES - 1));
  assign tmo_err = err_q;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      tcnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      tcnt_q <= (state_d != state_q || state_q == IDLE) ? '0 : tcnt_q + TW'(1);
      err_q <= timeout | (err_q & ~rd_rise);
    end
`else
  logic unused_tmo;
  assign unused_tmo = TIMEOUT_CYCLES != 0;
  assign timeout = 1'b0;
  assign tmo_err = 1'b0;
`endif
  always_ff @(posedge clk)
    if (push_ok) mem_q[wp_q] <= {z80_addr, z80_data_in};
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      iorq_q <= 2'b11;
      rd_q <= 2'b11;
      wr_q <= 2'b11;
      m1_q <= 2'b11;
      ack_q <= 2'b00;
      wr_hit_q <= 1'b0;
      rd_hit_q <= 1'b0;
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
      state_q <= IDLE;
      cmd_q <= '0;
      addr_q <= '0;
      ovf_q <= 1'b0;
      status_q <= '0;
    end else begin
      iorq_q <= {iorq_q[0], z80_iorq_n};
      rd_q <= {rd_q[0], z80_rd_n};
      wr_q <= {wr_q[0], z80_wr_n};
      m1_q <= {m1_q[0], z80_m1_n};
      ack_q <= {ack_q[0], cpu_cmd_ack};
      wr_hit_q <= wr_hit;
      rd_hit_q <= rd_hit;
      if (push_ok) wp_q <= wp_q + FIFO_AW'(1);
      if (pop) begin
        rp_q <= rp_q + FIFO_AW'(1);
        {addr_q, cmd_q} <= mem_q[rp_q];
      end
      cnt_q <= cnt_q + (FIFO_AW+1)'(push_ok) - (FIFO_AW+1)'(pop);
      state_q <= state_d;
      ovf_q <= ovf_d;
      status_q <= {4'b0, tmo_err, ovf_q, full, busy};
    end
endmodule

// File: tb/tb_z80_cmd_mailbox.sv
// tb_z80_cmd_mailbox: directed plus randomized bench for z80_cmd_mailbox against a queue-based model
`timescale 1ns/1ps
module tb_z80_cmd_mailbox;
  logic clk = 0, reset = 1;
  logic z80_iorq_n = 1, z80_rd_n = 1, z80_wr_n = 1, z80_m1_n = 1, cpu_cmd_ack = 0;
  logic [15:0] z80_addr = '0;
  logic [7:0] z80_data_in = '0;
  logic [7:0] z80_data_out, cpu_cmd;
  logic [15:0] cpu_address;
  logic z80_data_oe, cpu_cmd_en, busy;
  int checks = 0, errors = 0;
  logic [23:0] q[$];
  logic [23:0] inflight;
  bit inflight_v = 0, ovf_m = 0, err_m = 0;
  logic prev_en = 0;
  logic [23:0] prev_cmd = '0;

  z80_cmd_mailbox #(.CMD_PORT(8'h3F), .FIFO_AW(2), .TIMEOUT_CYCLES(100)) dut (
    .clk(clk), .reset(reset), .z80_iorq_n(z80_iorq_n), .z80_rd_n(z80_rd_n), .z80_wr_n(z80_wr_n),
    .z80_m1_n(z80_m1_n), .z80_addr(z80_addr), .z80_data_in(z80_data_in), .z80_data_out(z80_data_out),
    .z80_data_oe(z80_data_oe), .cpu_cmd(cpu_cmd), .cpu_address(cpu_address), .cpu_cmd_en(cpu_cmd_en),
    .cpu_cmd_ack(cpu_cmd_ack), .busy(busy));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic busy_m();
    return inflight_v || q.size() != 0;
  endfunction

  function automatic logic [7:0] status_m();
    return {4'b0, err_m, ovf_m, q.size() == 4, busy_m()};
  endfunction

  // model: a command goes straight to NIOS if nothing is in flight, else queues (4 deep) or is dropped
  task automatic model_push(input logic [23:0] c);
    if (q.size() == 4) ovf_m = 1;
    else q.push_back(c);
    if (!inflight_v && q.size() != 0) begin
      inflight = q.pop_front();
      inflight_v = 1;
    end
  endtask

  task automatic model_next();
    inflight_v = 0;
    if (q.size() != 0) begin
      inflight = q.pop_front();
      inflight_v = 1;
    end
  endtask

  task automatic z80_out(input logic [15:0] a, input logic [7:0] d);
    @(negedge clk);
    z80_addr = a; z80_data_in = d; z80_iorq_n = 0; z80_wr_n = 0;
    repeat (6) @(negedge clk);
    z80_iorq_n = 1; z80_wr_n = 1;
    repeat (6) @(negedge clk);
    if (a[7:0] == 8'h3F) model_push({a, d});
  endtask

  task automatic z80_in(input string tag);
    logic [7:0] exp;
    exp = status_m();
    @(negedge clk);
    z80_addr = {8'($urandom), 8'h3F}; z80_iorq_n = 0; z80_rd_n = 0;
    @(negedge clk);
    check({tag, "_oe"}, z80_data_oe, 1);
    check(tag, z80_data_out, exp);
    repeat (5) @(negedge clk);
    z80_iorq_n = 1; z80_rd_n = 1;
    repeat (6) @(negedge clk);
    ovf_m = 0; err_m = 0;
  endtask

  task automatic deliver(input int ack_dly, input int rel_dly);
    int n = 0;
    while (!cpu_cmd_en && n < 50) begin @(negedge clk); n++; end
    check("cmd_en_up", cpu_cmd_en, 1);
    check("cmd", cpu_cmd, inflight[7:0]);
    check("addr", cpu_address, inflight[23:8]);
    repeat (ack_dly) @(negedge clk);
    check("cmd_en_hold", cpu_cmd_en, 1);
    cpu_cmd_ack = 1;
    n = 0;
    while (cpu_cmd_en && n < 20) begin @(negedge clk); n++; end
    check("cmd_en_down", cpu_cmd_en, 0);
    repeat (rel_dly) @(negedge clk);
    cpu_cmd_ack = 0;
    repeat (6) @(negedge clk);
    model_next();
    check("busy_after", busy, busy_m());
  endtask

  always @(negedge clk) begin
    if (prev_en && cpu_cmd_en) check("cmd_stable", {8'h0, cpu_address, cpu_cmd}, {8'h0, prev_cmd});
    prev_en = cpu_cmd_en;
    prev_cmd = {cpu_address, cpu_cmd};
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit seen;
    logic [7:0] lb;
    repeat (3) @(negedge clk);
    check("rst_en", cpu_cmd_en, 0);
    check("rst_cmd", cpu_cmd, 0);
    check("rst_addr", cpu_address, 0);
    check("rst_busy", busy, 0);
    check("rst_status", z80_data_out, 0);
    check("rst_oe", z80_data_oe, 0);
    reset = 0;
    repeat (3) @(negedge clk);
    z80_out(16'h053F, 8'hA2);
    check("first_cmd", cpu_cmd, 8'hA2);
    check("first_addr", cpu_address, 16'h053F);
    deliver(10, 5);
    check("idle_busy", busy, 0);
    for (int i = 1; i <= 5; i++) z80_out({8'(i), 8'h3F}, 8'(i));
    check("full_en", cpu_cmd_en, 1);
    check("full_cmd", cpu_cmd, 8'h01);
    z80_out(16'h063F, 8'h06);
    z80_in("status_ovf");
    z80_in("status_cleared");
    while (inflight_v) deliver($urandom_range(0, 6), $urandom_range(0, 4));
    @(negedge clk);
    z80_addr = 16'h003F; z80_iorq_n = 0; z80_m1_n = 0; z80_rd_n = 0; z80_wr_n = 0;
    seen = 0;
    repeat (8) begin @(negedge clk); seen |= z80_data_oe; end
    z80_iorq_n = 1; z80_m1_n = 1; z80_rd_n = 1; z80_wr_n = 1;
    repeat (6) @(negedge clk);
    check("iack_oe", seen, 0);
    check("iack_busy", busy, 0);
    for (int i = 0; i < 3; i++) z80_out({8'h00, 8'h3F}, 8'h10 + 8'(i));
    for (int i = 0; i < 3; i++) begin
      check("order_cmd", cpu_cmd, 8'h10 + 8'(i));
      deliver($urandom_range(0, 6), $urandom_range(0, 4));
    end
    for (int r = 0; r < 20; r++) begin
      n = $urandom_range(1, 6);
      for (int i = 0; i < n; i++) begin
        lb = ($urandom_range(0, 4) == 0) ? 8'($urandom) : 8'h3F;
        z80_out({8'($urandom), lb}, 8'($urandom));
      end
      if ($urandom_range(0, 1) == 1) z80_in("status_rand");
      while (inflight_v) deliver($urandom_range(0, 8), $urandom_range(0, 4));
      z80_in("status_drained");
    end
    for (int i = 0; i < 3; i++) z80_out({8'h20 + 8'(i), 8'h3F}, 8'h20 + 8'(i));
    check("pre_rst_en", cpu_cmd_en, 1);
    @(negedge clk);
    #2 reset = 1;
    #1;
    check("async_rst_en", cpu_cmd_en, 0);
    check("async_rst_busy", busy, 0);
    check("async_rst_status", z80_data_out, 0);
    q.delete(); inflight_v = 0; ovf_m = 0; err_m = 0;
    @(negedge clk);
    reset = 0;
    seen = 0;
    repeat (20) begin @(negedge clk); seen |= cpu_cmd_en | busy; end
    check("post_rst_quiet", seen, 0);
    z80_out(16'h773F, 8'h5A);
    deliver(3, 2);
`ifdef CMD_TIMEOUT_EN
    z80_out(16'h013F, 8'hC1);
    z80_out(16'h023F, 8'hC2);
    n = 0;
    while (cpu_cmd_en && n < 300) begin @(negedge clk); n++; end
    check("tmo_first_drop", cpu_cmd_en, 0);
    err_m = 1;
    model_next();
    n = 0;
    while (!cpu_cmd_en && n < 10) begin @(negedge clk); n++; end
    check("tmo_next_en", cpu_cmd_en, 1);
    check("tmo_next_cmd", cpu_cmd, inflight[7:0]);
    n = 0;
    while (cpu_cmd_en && n < 300) begin n++; @(negedge clk); end
    check("tmo_cycles", n, 100);
    model_next();
    repeat (4) @(negedge clk);
    z80_in("status_tmo");
`else
    z80_out(16'h013F, 8'hC1);
    repeat (150) @(negedge clk);
    check("no_tmo_en", cpu_cmd_en, 1);
    z80_in("status_no_tmo");
    deliver(2, 2);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
